// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes I/S/B/J/U/Z/SH immediates from a raw instruction
// and registers them behind a valid/ready handshake, optionally with a 2-entry skid buffer.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      inst_i,
  input  logic [2:0]       imm_sel_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  imm_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             illegal_o
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // valid never depends on ready, and payload holds while valid & !ready.

  logic [XLEN-1:0]  imm_new;
  logic             ill_new;
  logic             unused_opcode;

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  imm_q, imm_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             ill_q, ill_d;
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic             skid_ill_q, skid_ill_d;
  logic             in_ready_q, in_ready_d;

  logic             in_xfer;
  logic             out_xfer;

  assign unused_opcode = ^inst_i[6:0];

  always_comb begin
    imm_new = '0;
    ill_new = 1'b0;
    case (imm_sel_i)
      3'd0: imm_new = XLEN'($signed(inst_i[31:20]));
      3'd1: imm_new = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
      3'd2: imm_new = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
      3'd3: imm_new = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
      3'd4: imm_new = XLEN'($signed({inst_i[31:12], 12'b0}));
      3'd5: imm_new = XLEN'(inst_i[19:15]);
      3'd6: imm_new = (XLEN == 64) ? XLEN'(inst_i[25:20]) : XLEN'(inst_i[24:20]);
      default: begin
        imm_new = '0;
        ill_new = 1'b1;
      end
    endcase
  end

  // The rst cycle never transfers downstream, so valid is masked while rst is high.
  assign out_valid_o = out_valid_q & ~rst;
  assign imm_o       = imm_q;
  assign tag_o       = tag_q;
  assign illegal_o   = ill_q;
  assign in_ready_o  = (SKID != 0) ? in_ready_q : (~out_valid_q | out_ready_i);

  assign in_xfer  = in_valid_i & in_ready_o;
  assign out_xfer = out_valid_o & out_ready_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    imm_d        = imm_q;
    tag_d        = tag_q;
    ill_d        = ill_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_tag_d   = skid_tag_q;
    skid_ill_d   = skid_ill_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // Full: input is blocked, only the skid entry can advance.
      if (out_xfer) begin
        imm_d        = skid_imm_q;
        tag_d        = skid_tag_q;
        ill_d        = skid_ill_q;
        skid_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      if ((SKID == 0) || !out_valid_q || out_xfer) begin
        out_valid_d = 1'b1;
        imm_d       = imm_new;
        tag_d       = tag_i;
        ill_d       = ill_new;
      end else begin
        skid_valid_d = 1'b1;
        skid_imm_d   = imm_new;
        skid_tag_d   = tag_i;
        skid_ill_d   = ill_new;
      end
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      imm_q        <= '0;
      tag_q        <= '0;
      ill_q        <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_tag_q   <= '0;
      skid_ill_q   <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      imm_q        <= imm_d;
      tag_q        <= tag_d;
      ill_q        <= ill_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_tag_q   <= skid_tag_d;
      skid_ill_q   <= skid_ill_d;
      in_ready_q   <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three instances (XLEN32/SKID1, XLEN64/SKID1, XLEN64/SKID0) share one
// stimulus stream; each is compared every cycle against its own queue-based reference.
module tb_imm_gen_pipe;

  typedef struct packed {
    logic [63:0] imm;
    logic [4:0]  tag;
    logic        ill;
  } ent_t;

  localparam int XL[3] = '{32, 64, 64};
  localparam int SK[3] = '{1, 1, 0};

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] inst;
  logic [2:0]  sel;
  logic [4:0]  tag;

  logic        o_ready[3];
  logic        o_valid[3];
  logic [63:0] o_imm[3];
  logic [4:0]  o_tag[3];
  logic        o_ill[3];
  logic [31:0] imm_a;
  logic [63:0] imm_b, imm_c;

  ent_t exp_q[3][$];
  bit   zf[3];
  bit   acc[3];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5), .SKID(1)) dut_a (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(o_ready[0]),
    .inst_i(inst), .imm_sel_i(sel), .tag_i(tag), .out_valid_o(o_valid[0]),
    .out_ready_i(out_ready), .imm_o(imm_a), .tag_o(o_tag[0]), .illegal_o(o_ill[0]));

  imm_gen_pipe #(.XLEN(64), .TAG_W(5), .SKID(1)) dut_b (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(o_ready[1]),
    .inst_i(inst), .imm_sel_i(sel), .tag_i(tag), .out_valid_o(o_valid[1]),
    .out_ready_i(out_ready), .imm_o(imm_b), .tag_o(o_tag[1]), .illegal_o(o_ill[1]));

  imm_gen_pipe #(.XLEN(64), .TAG_W(5), .SKID(0)) dut_c (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(o_ready[2]),
    .inst_i(inst), .imm_sel_i(sel), .tag_i(tag), .out_valid_o(o_valid[2]),
    .out_ready_i(out_ready), .imm_o(imm_c), .tag_o(o_tag[2]), .illegal_o(o_ill[2]));

  assign o_imm[0] = {32'b0, imm_a};
  assign o_imm[1] = imm_b;
  assign o_imm[2] = imm_c;

  // Immediate value straight from the format table, then truncated to xlen.
  function automatic logic [63:0] ref_imm(input logic [31:0] in, input logic [2:0] s, input int xlen);
    longint v;
    case (s)
      3'd0: begin v = longint'(in[31:20]); if (in[31]) v = v - 4096; end
      3'd1: begin v = longint'({in[31:25], in[11:7]}); if (in[31]) v = v - 4096; end
      3'd2: begin v = longint'({in[31], in[7], in[30:25], in[11:8], 1'b0}); if (in[31]) v = v - 8192; end
      3'd3: begin v = longint'({in[31], in[19:12], in[20], in[30:21], 1'b0}); if (in[31]) v = v - 2097152; end
      3'd4: begin v = longint'({in[31:12], 12'b0}); if (in[31]) v = v - 64'sd4294967296; end
      3'd5: v = longint'(in[19:15]);
      3'd6: v = (xlen == 64) ? longint'(in[25:20]) : longint'(in[24:20]);
      default: v = 0;
    endcase
    if (xlen == 32) return {32'b0, v[31:0]};
    return v;
  endfunction

  function automatic bit exp_ready(input int k);
    if (SK[k] != 0) return exp_q[k].size() < 2;
    return (exp_q[k].size() == 0) || out_ready;
  endfunction

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  task automatic model_step(input int k);
    bit   rdy;
    ent_t e;
    acc[k] = 1'b0;
    if (rst) begin
      exp_q[k].delete();
      zf[k] = 1'b1;
    end else if (flush) begin
      exp_q[k].delete();
    end else begin
      rdy = exp_ready(k);
      if (exp_q[k].size() > 0 && out_ready) void'(exp_q[k].pop_front());
      if (in_valid && rdy) begin
        e.imm = ref_imm(inst, sel, XL[k]);
        e.tag = tag;
        e.ill = (sel == 3'd7);
        exp_q[k].push_back(e);
        zf[k]  = 1'b0;
        acc[k] = 1'b1;
      end
    end
  endtask

  task automatic check(input int k);
    ent_t e;
    chk($sformatf("d%0d_valid", k), 64'(o_valid[k]), 64'(!rst && exp_q[k].size() > 0));
    chk($sformatf("d%0d_ready", k), 64'(o_ready[k]), 64'(exp_ready(k)));
    if (exp_q[k].size() > 0) begin
      e = exp_q[k][0];
      chk($sformatf("d%0d_imm", k), o_imm[k], e.imm);
      chk($sformatf("d%0d_tag", k), 64'(o_tag[k]), 64'(e.tag));
      chk($sformatf("d%0d_ill", k), 64'(o_ill[k]), 64'(e.ill));
    end else if (zf[k]) begin
      chk($sformatf("d%0d_imm_rst", k), o_imm[k], 64'd0);
      chk($sformatf("d%0d_tag_rst", k), 64'(o_tag[k]), 64'd0);
      chk($sformatf("d%0d_ill_rst", k), 64'(o_ill[k]), 64'd0);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    @(negedge clk);
    for (int k = 0; k < 3; k++) check(k);
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [31:0] w, input logic [4:0] t);
    in_valid = v;
    sel      = s;
    inst     = w;
    tag      = t;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 3'd0, 32'd0, 5'd0);
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // Directed formats
    drive(1'b1, 3'd0, 32'hFFF00093, 5'd9);
    cycle();
    chk("t1_imm32", o_imm[0], 64'h00000000FFFFFFFF);
    chk("t1_ill", 64'(o_ill[0]), 64'd0);
    drive(1'b1, 3'd4, 32'h800002B7, 5'd10);
    cycle();
    chk("t2_u64", o_imm[1], 64'hFFFFFFFF80000000);
    chk("t2_u32", o_imm[0], 64'h0000000080000000);
    drive(1'b1, 3'd2, 32'hFE000EE3, 5'd11);
    cycle();
    chk("t2_b64", o_imm[1], 64'hFFFFFFFFFFFFFFFC);
    drive(1'b1, 3'd6, 32'h03F00013, 5'd12);
    cycle();
    chk("t3_sh64", o_imm[1], 64'd63);
    chk("t3_sh32", o_imm[0], 64'd31);
    drive(1'b1, 3'd5, 32'h000F8073, 5'd13);
    cycle();
    chk("t3_z", o_imm[1], 64'd31);
    drive(1'b1, 3'd7, 32'hFFFFFFFF, 5'd14);
    cycle();
    chk("t3_ill_imm", o_imm[1], 64'd0);
    chk("t3_ill", 64'(o_ill[1]), 64'd1);
    drive(1'b0, 3'd0, 32'd0, 5'd0);
    cycle();

    // Backpressure fills output + skid, then drains in order
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 32'h00100093, 5'd1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (acc[0]) tag = tag + 5'd1;
    end
    chk("t4_full_ready", 64'(o_ready[0]), 64'd0);
    chk("t4_head", 64'(o_tag[0]), 64'd1);
    out_ready = 1'b1;
    cycle();
    chk("t4_second", 64'(o_tag[0]), 64'd2);
    if (acc[0]) tag = tag + 5'd1;
    cycle();
    chk("t4_third", 64'(o_tag[0]), 64'd3);
    chk("t4_third_valid", 64'(o_valid[0]), 64'd1);
    in_valid = 1'b0;
    cycle();
    chk("t4_drained", 64'(o_valid[0]), 64'd0);

    // Flush with two held entries and a same-cycle input
    out_ready = 1'b0;
    drive(1'b1, 3'd1, 32'h12345678, 5'd4);
    cycle();
    tag = 5'd5;
    cycle();
    flush = 1'b1;
    tag = 5'd6;
    cycle();
    chk("t5_valid", 64'(o_valid[0]), 64'd0);
    chk("t5_ready", 64'(o_ready[0]), 64'd1);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycle();
    chk("t5_dropped", 64'(o_valid[0]), 64'd0);

    // Reset mid-stream
    out_ready = 1'b0;
    drive(1'b1, 3'd3, 32'hFFFFF0EF, 5'd7);
    cycle();
    rst = 1'b1;
    cycle();
    chk("t6_valid", 64'(o_valid[0]), 64'd0);
    chk("t6_imm", o_imm[0], 64'd0);
    chk("t6_tag", 64'(o_tag[0]), 64'd0);
    chk("t6_ill", 64'(o_ill[0]), 64'd0);
    rst = 1'b0;

    // Random soak
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)));
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
